// File: rtl/ntt_pkg.sv
// Shared constants, types, zeta ROM and Barrett reduction for the Kyber
// polynomial transform cores (n=256, q=3329).
package ntt_pkg;

  localparam int Q      = 3329;
  localparam int LANE_W = 16;
  localparam int WORDS  = 32;
  localparam int N      = 256;
  localparam int COEF_W = 12;
  localparam int LANES  = 8;
  localparam int BUS_W  = LANES * LANE_W;

  // m = floor(2^26 / Q); with inputs below 2^24 the quotient estimate is short
  // by at most one, so a single conditional subtract finishes the reduction.
  localparam int BARRETT_SHIFT = 26;
  localparam int BARRETT_M     = 20158;

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_OUT,
    S_DONE
  } state_t;

  // zeta[k] = 17^BitRev7(k) mod Q
  localparam coef_t ZETA_ROM [128] = '{
    12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
    12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
    12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
    12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
    12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
    12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
    12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
    12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
    12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
    12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
    12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
    12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
    12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
    12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
    12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
    12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
  };

  function automatic coef_t barrett_reduce(input logic [23:0] x);
    logic [38:0] prod;
    logic [12:0] qe;
    logic [23:0] r;
    prod = 39'(x) * 39'(BARRETT_M);
    qe   = 13'(prod >> BARRETT_SHIFT);
    r    = x - 24'(qe) * 24'(Q);
    if (r >= 24'(Q)) r = r - 24'(Q);
    return coef_t'(r);
  endfunction

endpackage

// File: rtl/ntt_core_if.sv
// Load/stream bus of the transform core: start pulse, valid/ready input
// words, valid-only output words and the done level.
interface ntt_core_if;
  import ntt_pkg::*;

  logic             start;
  logic [BUS_W-1:0] data_in;
  logic             valid_in;
  logic             ready_in;
  logic [BUS_W-1:0] data_out;
  logic             valid_out;
  logic             done;

  modport master (output start, data_in, valid_in,
                  input  ready_in, data_out, valid_out, done);
  modport slave  (input  start, data_in, valid_in,
                  output ready_in, data_out, valid_out, done);
endinterface

// File: rtl/ntt_butterfly.sv
// Combinational Cooley-Tukey butterfly: t = zeta*b mod Q, returns (a+t, a-t)
// fully reduced. Shared with the inverse transform core.
module ntt_butterfly
  import ntt_pkg::*;
(
  input  coef_t i_a,
  input  coef_t i_b,
  input  coef_t i_zeta,
  output coef_t o_a,
  output coef_t o_b
);

  coef_t       w_t;
  logic [12:0] w_sum;
  logic [12:0] w_diff;

  assign w_t    = barrett_reduce(24'(i_b) * 24'(i_zeta));
  assign w_sum  = 13'(i_a) + 13'(w_t);
  assign w_diff = 13'(i_a) + 13'(Q) - 13'(w_t);

  assign o_a = (w_sum  >= 13'(Q)) ? coef_t'(w_sum  - 13'(Q)) : coef_t'(w_sum);
  assign o_b = (w_diff >= 13'(Q)) ? coef_t'(w_diff - 13'(Q)) : coef_t'(w_diff);

endmodule

// File: rtl/ntt_core.sv
// Forward Kyber NTT: loads 32 words, runs 896 butterflies one per cycle, streams
// 32 words out. Define NTT_INPUT_REDUCE_EN to reduce full 16-bit input lanes mod Q.
module ntt_core
  import ntt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ntt_core_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_cnt;
  logic [2:0]       r_layer;
  logic [6:0]       r_bidx;
  coef_t            r_coef [N];
  coef_t            w_lane_in [LANES];
  logic [BUS_W-1:0] w_out_word;
  logic             w_load_fire;
  logic             w_last_bfly;
  logic [7:0]       w_len, w_mask, w_bidx8, w_j, w_jl;
  logic [6:0]       w_k;
  coef_t            w_a_new, w_b_new;

  assign w_load_fire = (r_state == S_LOAD) && bus.valid_in;
  assign w_last_bfly = (r_layer == 3'd6) && (r_bidx == 7'd127);

  // Butterfly b of a layer: insert a zero bit at position log2(len) to get j.
  assign w_len   = 8'd1 << (3'd7 - r_layer);
  assign w_mask  = w_len - 8'd1;
  assign w_bidx8 = {1'b0, r_bidx};
  assign w_j     = ((w_bidx8 & ~w_mask) << 1) | (w_bidx8 & w_mask);
  assign w_jl    = w_j | w_len;
  assign w_k     = 7'((8'd1 << r_layer) | (w_bidx8 >> (3'd7 - r_layer)));

  ntt_butterfly u_bfly (
    .i_a    (r_coef[w_j]),
    .i_b    (r_coef[w_jl]),
    .i_zeta (ZETA_ROM[w_k]),
    .o_a    (w_a_new),
    .o_b    (w_b_new)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef NTT_INPUT_REDUCE_EN
    assign w_lane_in[gi] = barrett_reduce(24'(bus.data_in[LANE_W*gi +: LANE_W]));
`else
    logic w_unused_nib;
    assign w_unused_nib  = ^bus.data_in[LANE_W*gi+COEF_W +: LANE_W-COEF_W];
    assign w_lane_in[gi] = bus.data_in[LANE_W*gi +: COEF_W];
`endif
    assign w_out_word[LANE_W*gi +: LANE_W] = {4'b0, r_coef[{r_cnt, 3'(gi)}]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_LOAD;
      S_LOAD:  if (w_load_fire && (r_cnt == 5'd31)) w_state_next = S_COMP;
      S_COMP:  if (w_last_bfly) w_state_next = S_OUT;
      S_OUT:   if (r_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE:  if (bus.start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  // r_cnt wraps to 0 after word 31, so it is already cleared for the next phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_layer <= '0;
      r_bidx  <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (w_load_fire) r_cnt <= r_cnt + 5'd1;
        S_COMP: begin
          r_bidx <= r_bidx + 7'd1;
          if (r_bidx == 7'd127) r_layer <= (r_layer == 3'd6) ? 3'd0 : r_layer + 3'd1;
        end
        S_OUT:  r_cnt <= r_cnt + 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      for (int l = 0; l < LANES; l++) r_coef[{r_cnt, 3'(l)}] <= w_lane_in[l];
    end else if (r_state == S_COMP) begin
      r_coef[w_j]  <= w_a_new;
      r_coef[w_jl] <= w_b_new;
    end
  end

  assign bus.ready_in  = (r_state == S_LOAD);
  assign bus.valid_out = (r_state == S_OUT);
  assign bus.done      = (r_state == S_DONE);
  assign bus.data_out  = (r_state == S_OUT) ? w_out_word : '0;

endmodule

// File: tb/tb_ntt_core.sv
// Self-checking bench for ntt_core against a plain-arithmetic FIPS 203
// Algorithm 9 reference model.
module tb_ntt_core;

  localparam int QM = 3329;
  localparam logic [127:0] EXP_D0 = 128'h00000001000000010000000100000001;
  localparam logic [127:0] EXP_D1 = 128'h00010000000100000001000000010000;

  typedef int poly_t [256];
  typedef logic [127:0] word_arr_t [32];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  ntt_core_if bus ();

  ntt_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int modpow(input int b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % QM;
    return int'(r);
  endfunction

  function automatic int bitrev7(input int k);
    int r = 0;
    for (int i = 0; i < 7; i++) r |= ((k >> i) & 1) << (6 - i);
    return r;
  endfunction

  function automatic poly_t ntt_ref(input poly_t fin);
    poly_t f = fin;
    int k = 1;
    int j;
    int z, t;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        z = modpow(17, bitrev7(k));
        k++;
        for (j = st; j < st + len; j++) begin
          t = (z * f[j + len]) % QM;
          f[j + len] = (f[j] - t + QM) % QM;
          f[j] = (f[j] + t) % QM;
        end
      end
    end
    return f;
  endfunction

  function automatic logic [127:0] pack_word(input poly_t f, input int w);
    logic [127:0] r = '0;
    for (int l = 0; l < 8; l++) r[16*l +: 16] = 16'(f[8*w + l]);
    return r;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load_poly(input poly_t f, input bit gaps, output int accepted, output int not_ready);
    int cyc = 0;
    bit gap_done = 1'b0;
    accepted = 0;
    not_ready = 0;
    while (accepted < 32 && cyc < 400) begin
      if (gaps && (accepted % 3 == 2) && !gap_done) begin
        bus.valid_in = 1'b0;
        gap_done = 1'b1;
      end else begin
        bus.valid_in = 1'b1;
        bus.data_in  = pack_word(f, accepted);
        if (bus.ready_in) begin
          accepted++;
          gap_done = 1'b0;
        end else begin
          not_ready++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic collect(output word_arr_t words, output int latency, output int bad_valid);
    latency = 0;
    bad_valid = 0;
    while (!bus.valid_out && latency < 2000) begin
      @(negedge clk);
      latency++;
    end
    for (int i = 0; i < 32; i++) begin
      if (bus.valid_out !== 1'b1) bad_valid++;
      words[i] = bus.data_out;
      @(negedge clk);
    end
  endtask

  task automatic run_transform(input poly_t f, output word_arr_t words, output int accepted,
                               output int latency, output int bad_valid);
    int nr;
    pulse_start();
    load_poly(f, 1'b0, accepted, nr);
    collect(words, latency, bad_valid);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in: got %b want 0", bus.ready_in); end
    n_tests++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
    rst = 1'b1;
    $display("[TB] reset: idle outputs checked");
  endtask

  task automatic test_zero();
    poly_t f = '{default: 0};
    word_arr_t got;
    int acc, nr, lat, bad;
    pulse_start();
    n_tests++; if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after_start: got %b want 1", bus.ready_in); end
    load_poly(f, 1'b0, acc, nr);
    n_tests++; if (acc !== 32) begin n_fail++; $display("FAIL zero_accepted: got %0d want 32", acc); end
    collect(got, lat, bad);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL zero_valid_gaps: got %0d want 0", bad); end
    for (int w = 0; w < 32; w++) begin
      n_tests++; if (got[w] !== 128'h0) begin n_fail++; $display("FAIL zero_word%0d: got %h want 0", w, got[w]); end
    end
    n_tests++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL zero_valid_after: got %b want 0", bus.valid_out); end
    repeat (5) @(negedge clk);
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done_held: got %b want 1", bus.done); end
    $display("[TB] zero vector: latency %0d cycles", lat);
  endtask

  task automatic test_delta0();
    poly_t f = '{default: 0};
    word_arr_t got;
    int acc, lat, bad;
    f[0] = 1;
    run_transform(f, got, acc, lat, bad);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL delta0_valid_gaps: got %0d want 0", bad); end
    for (int w = 0; w < 32; w++) begin
      n_tests++; if (got[w] !== EXP_D0) begin n_fail++; $display("FAIL delta0_word%0d: got %h want %h", w, got[w], EXP_D0); end
    end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL delta0_done: got %b want 1", bus.done); end
    $display("[TB] f[0]=1 vector: 32 words compared");
  endtask

  task automatic test_random();
    poly_t f, e;
    word_arr_t got;
    int acc, nr, lat, bad;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 256; i++) f[i] = int'($urandom_range(QM - 1));
      e = ntt_ref(f);
      pulse_start();
      load_poly(f, 1'b1, acc, nr);
      n_tests++; if (acc !== 32) begin n_fail++; $display("FAIL rand%0d_accepted: got %0d want 32", v, acc); end
      n_tests++; if (nr !== 0) begin n_fail++; $display("FAIL rand%0d_ready_low_in_load: got %0d want 0", v, nr); end
      for (int x = 0; x < 3; x++) begin
        bus.valid_in = 1'b1;
        bus.data_in = {4{$urandom()}};
        n_tests++; if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL rand%0d_extra_ready: got %b want 0", v, bus.ready_in); end
        @(negedge clk);
      end
      bus.valid_in = 1'b0;
      collect(got, lat, bad);
      n_tests++; if (lat + 3 > 1100) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want <=1100", v, lat + 3); end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_valid_gaps: got %0d want 0", v, bad); end
      for (int w = 0; w < 32; w++) begin
        n_tests++;
        if (got[w] !== pack_word(e, w)) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h want %h", v, w, got[w], pack_word(e, w));
        end
      end
      $display("[TB] random vector %0d: latency %0d cycles, 32 words compared", v, lat + 3);
    end
  endtask

  task automatic test_reset_in_comp();
    poly_t f, d0;
    word_arr_t got;
    int acc, nr, lat, bad, busy;
    for (int i = 0; i < 256; i++) f[i] = int'($urandom_range(QM - 1));
    pulse_start();
    load_poly(f, 1'b0, acc, nr);
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL comp_rst_ready_in: got %b want 0", bus.ready_in); end
    n_tests++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL comp_rst_valid_out: got %b want 0", bus.valid_out); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL comp_rst_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst = 1'b1;
    busy = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.valid_out || bus.done || bus.ready_in) busy++;
    end
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL comp_rst_idle_activity: got %0d cycles want 0", busy); end
    d0 = '{default: 0};
    d0[0] = 1;
    run_transform(d0, got, acc, lat, bad);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL comp_rst_valid_gaps: got %0d want 0", bad); end
    for (int w = 0; w < 32; w++) begin
      n_tests++; if (got[w] !== EXP_D0) begin n_fail++; $display("FAIL comp_rst_word%0d: got %h want %h", w, got[w], EXP_D0); end
    end
    $display("[TB] reset during COMP: abort and restart checked");
  endtask

  task automatic test_start_in_out();
    poly_t f = '{default: 0};
    word_arr_t got;
    int acc, nr, lat, bad;
    f[1] = 1;
    pulse_start();
    load_poly(f, 1'b0, acc, nr);
    lat = 0;
    while (!bus.valid_out && lat < 2000) begin @(negedge clk); lat++; end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus.start = (i == 5);
      if (bus.valid_out !== 1'b1) bad++;
      got[i] = bus.data_out;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL out_start_valid_gaps: got %0d want 0", bad); end
    for (int w = 0; w < 32; w++) begin
      n_tests++; if (got[w] !== EXP_D1) begin n_fail++; $display("FAIL delta1_word%0d: got %h want %h", w, got[w], EXP_D1); end
    end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL out_start_done: got %b want 1", bus.done); end
    n_tests++; if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL out_start_ready: got %b want 0", bus.ready_in); end
    pulse_start();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_start_done: got %b want 0", bus.done); end
    n_tests++; if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL done_start_ready: got %b want 1", bus.ready_in); end
    f = '{default: 0};
    load_poly(f, 1'b0, acc, nr);
    collect(got, lat, bad);
    n_tests++; if (got[0] !== 128'h0) begin n_fail++; $display("FAIL done_start_word0: got %h want 0", got[0]); end
    $display("[TB] start in OUT ignored, start in DONE reloads");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_zero();
    test_delta0();
    test_random();
    test_reset_in_comp();
    test_start_in_out();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
